// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

    localparam logic [3:0]  OPC_HLT   = 4'b1111;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN,
        HALTED
    } fetchState_t;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit adder/subtractor. The result wraps modulo 2^16 and no carry is reported.
// Ports:
//   a, b  in   16  operands
//   sub   in   1   0: a + b, 1: a - b
//   sum   out  16  result
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    // Two's-complement subtract: invert b and inject the carry-in.
    assign sum = a + (b ^ {16{sub}}) + {15'd0, sub};

endmodule

// File: rtl/pc_register.sv
// 16-bit program-counter register with load enable and asynchronous active-low reset.
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset to RESET_VAL
//   en     in   1   load d on the next rising edge
//   d      in   16  next PC
//   q      out  16  current PC
module pc_register #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives the instruction-memory address and loads the IF/ID register.
// Handles hazard stall, branch redirect/flush and the freeze that follows a fetched HLT.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count / flush_count outputs.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            hold PC, IF/ID and FSM state
//   PCSel            redirect to PC_plusImm and squash the current fetch
//   PC_plusImm       branch target
//   imem_addr        instruction address (= PC)
//   imem_data        instruction at imem_addr (combinational read)
//   currInstruction  IF/ID instruction
//   PC_plus4         IF/ID PC of that instruction + PC_INC
//   valid_ID         IF/ID holds a real instruction
//   halted           fetch frozen after an accepted HLT
//   fetch_count      (optional) valid IF/ID loads, saturating
//   flush_count      (optional) branch squashes, saturating
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        PCSel,
    input  logic [15:0] PC_plusImm,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] currInstruction,
    output logic [15:0] PC_plus4,
    output logic        valid_ID,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    fetchState_t state, nextState;

    logic [15:0] pc;
    logic [15:0] pcPlusInc;
    logic [15:0] pcNext;
    logic        pcEn;
    logic        isHlt;
    logic        ifidLoad;
    logic        ifidBubble;
    logic        flushEvt;

    assign isHlt     = (imem_data[15:12] == OPC_HLT);
    assign imem_addr = pc;

    addsub_16bit uPcAdd (
        .a   (pc),
        .b   (PC_INC),
        .sub (1'b0),
        .sum (pcPlusInc)
    );

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) uPcReg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pcEn),
        .d     (pcNext),
        .q     (pc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next state: stall freezes, a redirect always returns to RUN, HLT only halts from RUN.
    always_comb begin
        nextState = state;
        if (!stall) begin
            if (PCSel) begin
                nextState = RUN;
            end else if (state == RUN && isHlt) begin
                nextState = HALTED;
            end
        end
    end

    // Control outputs.
    always_comb begin
        pcEn       = 1'b0;
        pcNext     = pcPlusInc;
        ifidLoad   = 1'b0;
        ifidBubble = 1'b0;
        flushEvt   = 1'b0;
        halted     = (state == HALTED);
        if (!stall) begin
            if (PCSel) begin
                pcEn       = 1'b1;
                pcNext     = PC_plusImm;
                ifidBubble = 1'b1;
                flushEvt   = 1'b1;
            end else if (state == HALTED) begin
                ifidBubble = 1'b1;
            end else begin
                // HLT is passed to decode but the PC stays on it.
                ifidLoad = 1'b1;
                pcEn     = !isHlt;
            end
        end
    end

    // IF/ID pipeline register. PC_plus4 is left as-is for bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            currInstruction <= NOP_INSTR;
            PC_plus4        <= 16'h0000;
            valid_ID        <= 1'b0;
        end else if (ifidBubble) begin
            currInstruction <= NOP_INSTR;
            valid_ID        <= 1'b0;
        end else if (ifidLoad) begin
            currInstruction <= imem_data;
            PC_plus4        <= pcPlusInc;
            valid_ID        <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            if (ifidLoad && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (flushEvt && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        PCSel;
    logic [15:0] PC_plusImm;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] currInstruction;
    logic [15:0] PC_plus4;
    logic        valid_ID;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    logic [15:0] mem [0:63];
    int tests;
    int fails;

    // Reference model: architectural view of the fetch stage.
    logic [15:0] mPc;
    logic        mHalted;
    logic [15:0] mInstr;
    logic [15:0] mPc4;
    logic        mValid;
    longint      mFetch;
    longint      mFlush;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .PCSel           (PCSel),
        .PC_plusImm      (PC_plusImm),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .currInstruction (currInstruction),
        .PC_plus4        (PC_plus4),
        .valid_ID        (valid_ID),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] randWord();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF) w[15:12] = 4'h1;
        return w;
    endfunction

    task automatic modelReset();
        mPc = 16'h0000; mHalted = 1'b0; mInstr = 16'h0000; mPc4 = 16'h0000;
        mValid = 1'b0; mFetch = 0; mFlush = 0;
    endtask

    task automatic modelStep();
        logic [15:0] data;
        data = mem[mPc[7:2]];
        if (!stall) begin
            if (PCSel) begin
                mPc = PC_plusImm; mInstr = 16'h0000; mValid = 1'b0; mHalted = 1'b0;
                mFlush = mFlush + 1;
            end else if (mHalted) begin
                mInstr = 16'h0000; mValid = 1'b0;
            end else begin
                mInstr = data; mPc4 = mPc + 16'd4; mValid = 1'b1; mFetch = mFetch + 1;
                if (data[15:12] == 4'hF) mHalted = 1'b1;
                else mPc = mPc + 16'd4;
            end
        end
    endtask

    // Inputs are stable here; advance model and DUT by one clock, land 1 time unit after the edge.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stall = 1'b0; PCSel = 1'b0; PC_plusImm = 16'h0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic fillMem(input int hltPct);
        for (int i = 0; i < 64; i++) begin
            mem[i] = randWord();
            if ($urandom_range(0, 99) < hltPct) mem[i][15:12] = 4'hF;
        end
    endtask

    task automatic test_reset();
        fillMem(0);
        mem[0] = 16'h1123;
        stall = 1'b0; PCSel = 1'b0; PC_plusImm = 16'h0000;
        rst_n = 1'b0;
        #2;
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
        tests++; if (currInstruction !== 16'h0000) begin fails++; $display("FAIL reset_instr got %h exp 0000", currInstruction); end
        tests++; if (PC_plus4 !== 16'h0000) begin fails++; $display("FAIL reset_pc4 got %h exp 0000", PC_plus4); end
        tests++; if (valid_ID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_ID); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_sequential();
        tick();
        tests++; if (currInstruction !== 16'h1123) begin fails++; $display("FAIL seq_instr got %h exp 1123", currInstruction); end
        tests++; if (PC_plus4 !== 16'h0004) begin fails++; $display("FAIL seq_pc4 got %h exp 0004", PC_plus4); end
        tests++; if (valid_ID !== 1'b1) begin fails++; $display("FAIL seq_valid got %b exp 1", valid_ID); end
        tests++; if (imem_addr !== 16'h0004) begin fails++; $display("FAIL seq_addr got %h exp 0004", imem_addr); end
        tick();
    endtask

    task automatic test_stall();
        logic [15:0] held;
        held = mem[1];
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (imem_addr !== 16'h0008) begin fails++; $display("FAIL stall_addr got %h exp 0008", imem_addr); end
            tests++; if (currInstruction !== held) begin fails++; $display("FAIL stall_instr got %h exp %h", currInstruction, held); end
            tests++; if (valid_ID !== 1'b1) begin fails++; $display("FAIL stall_valid got %b exp 1", valid_ID); end
        end
        stall = 1'b0;
        tick();
        tests++; if (currInstruction !== mem[2]) begin fails++; $display("FAIL unstall_instr got %h exp %h", currInstruction, mem[2]); end
        tests++; if (PC_plus4 !== 16'h000C) begin fails++; $display("FAIL unstall_pc4 got %h exp 000c", PC_plus4); end
        tests++; if (imem_addr !== 16'h000C) begin fails++; $display("FAIL unstall_addr got %h exp 000c", imem_addr); end
    endtask

    task automatic test_branch();
        PCSel = 1'b1; PC_plusImm = 16'h0040;
        tick();
        PCSel = 1'b0;
        tests++; if (imem_addr !== 16'h0040) begin fails++; $display("FAIL br_addr got %h exp 0040", imem_addr); end
        tests++; if (valid_ID !== 1'b0) begin fails++; $display("FAIL br_valid got %b exp 0", valid_ID); end
        tests++; if (currInstruction !== 16'h0000) begin fails++; $display("FAIL br_instr got %h exp 0000", currInstruction); end
        tick();
        tests++; if (currInstruction !== mem[16]) begin fails++; $display("FAIL br_tgt_instr got %h exp %h", currInstruction, mem[16]); end
        tests++; if (PC_plus4 !== 16'h0044) begin fails++; $display("FAIL br_tgt_pc4 got %h exp 0044", PC_plus4); end
    endtask

    task automatic test_halt();
        fillMem(0);
        mem[4] = 16'hF000;
        doReset();
        for (int i = 0; i < 4; i++) tick();
        tests++; if (imem_addr !== 16'h0010) begin fails++; $display("FAIL hlt_pre_addr got %h exp 0010", imem_addr); end
        tick();
        tests++; if (currInstruction !== 16'hF000) begin fails++; $display("FAIL hlt_instr got %h exp f000", currInstruction); end
        tests++; if (valid_ID !== 1'b1) begin fails++; $display("FAIL hlt_valid got %b exp 1", valid_ID); end
        tests++; if (PC_plus4 !== 16'h0014) begin fails++; $display("FAIL hlt_pc4 got %h exp 0014", PC_plus4); end
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_halted got %b exp 1", halted); end
        tests++; if (imem_addr !== 16'h0010) begin fails++; $display("FAIL hlt_addr got %h exp 0010", imem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (valid_ID !== 1'b0) begin fails++; $display("FAIL hlt_bubble_valid got %b exp 0", valid_ID); end
            tests++; if (imem_addr !== 16'h0010) begin fails++; $display("FAIL hlt_frozen_addr got %h exp 0010", imem_addr); end
            tests++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_stay got %b exp 1", halted); end
        end
        PCSel = 1'b1; PC_plusImm = 16'h0080;
        tick();
        PCSel = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL hlt_exit got %b exp 0", halted); end
        tests++; if (imem_addr !== 16'h0080) begin fails++; $display("FAIL hlt_exit_addr got %h exp 0080", imem_addr); end
    endtask

    task automatic test_hlt_squash_and_wrap();
        mem[mPc[7:2]] = 16'hF123;
        PCSel = 1'b1; PC_plusImm = 16'h0044;
        tick();
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL sq_halted got %b exp 0", halted); end
        tests++; if (imem_addr !== 16'h0044) begin fails++; $display("FAIL sq_addr got %h exp 0044", imem_addr); end
        tests++; if (valid_ID !== 1'b0) begin fails++; $display("FAIL sq_valid got %b exp 0", valid_ID); end
        mem[63] = 16'h2345;
        PC_plusImm = 16'hFFFC;
        tick();
        PCSel = 1'b0;
        tick();
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_addr got %h exp 0000", imem_addr); end
        tests++; if (PC_plus4 !== 16'h0000) begin fails++; $display("FAIL wrap_pc4 got %h exp 0000", PC_plus4); end
        tests++; if (currInstruction !== 16'h2345) begin fails++; $display("FAIL wrap_instr got %h exp 2345", currInstruction); end
    endtask

    task automatic test_reset_mid();
        mem[8] = 16'h3333;
        PCSel = 1'b1; PC_plusImm = 16'h0020;
        tick();
        PCSel = 1'b0;
        tick();
        tests++; if (valid_ID !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b exp 1", valid_ID); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL mid_addr got %h exp 0000", imem_addr); end
        tests++; if (valid_ID !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", valid_ID); end
        tests++; if (currInstruction !== 16'h0000) begin fails++; $display("FAIL mid_instr got %h exp 0000", currInstruction); end
        tests++; if (PC_plus4 !== 16'h0000) begin fails++; $display("FAIL mid_pc4 got %h exp 0000", PC_plus4); end
`ifdef FETCH_PERF_CNT_EN
        tests++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL mid_fcnt got %0d exp 0", fetch_count); end
        tests++; if (flush_count !== 16'd0) begin fails++; $display("FAIL mid_flcnt got %0d exp 0", flush_count); end
`endif
        #1;
        rst_n = 1'b1;
        modelReset();
        tick();
        tests++; if (currInstruction !== mem[0]) begin fails++; $display("FAIL mid_first_instr got %h exp %h", currInstruction, mem[0]); end
        tests++; if (PC_plus4 !== 16'h0004) begin fails++; $display("FAIL mid_first_pc4 got %h exp 0004", PC_plus4); end
    endtask

    task automatic test_random();
        fillMem(12);
        doReset();
        for (int i = 0; i < 400; i++) begin
            stall      = ($urandom_range(0, 3) == 0);
            PCSel      = ($urandom_range(0, 6) == 0);
            PC_plusImm = 16'($urandom) & 16'hFFFC;
            tick();
            tests++; if (imem_addr !== mPc) begin fails++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, mPc); end
            tests++; if (valid_ID !== mValid) begin fails++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, valid_ID, mValid); end
            tests++; if (currInstruction !== mInstr) begin fails++; $display("FAIL rnd_instr cyc %0d got %h exp %h", i, currInstruction, mInstr); end
            tests++; if (halted !== mHalted) begin fails++; $display("FAIL rnd_halted cyc %0d got %b exp %b", i, halted, mHalted); end
            if (mValid) begin
                tests++; if (PC_plus4 !== mPc4) begin fails++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", i, PC_plus4, mPc4); end
            end
`ifdef FETCH_PERF_CNT_EN
            tests++; if (fetch_count !== 32'(mFetch)) begin fails++; $display("FAIL rnd_fcnt cyc %0d got %0d exp %0d", i, fetch_count, mFetch); end
            tests++; if (flush_count !== 16'(mFlush)) begin fails++; $display("FAIL rnd_flcnt cyc %0d got %0d exp %0d", i, flush_count, mFlush); end
`endif
        end
        stall = 1'b0; PCSel = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        PCSel = 1'b0;
        PC_plusImm = 16'h0000;
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_hlt_squash_and_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
